// File: rtl/counter_modn_if.sv
// Bus bundle for counter_modn: control inputs toward the counter, count/status back.
interface counter_modn_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             wrap_en;
    logic [WIDTH-1:0] q;
    logic             pgt;
    logic             tc;
    logic             halted;

    // Controller side drives the controls and observes the count.
    modport master (
        output en, up, load, din, wrap_en,
        input  q, pgt, tc, halted
    );

    // Counter side consumes the controls and drives the count.
    modport slave (
        input  en, up, load, din, wrap_en,
        output q, pgt, tc, halted
    );
endinterface

// File: rtl/counter_modn.sv
// Modulo-N up/down counter with synchronous load, wrap or saturate terminal mode,
// a registered carry/borrow pulse (pgt) and a combinational terminal-count flag (tc)
// intended to enable the next digit of a cascade.
module counter_modn #(
    parameter int unsigned MODULUS     = 8,
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned RESET_VALUE = 0
) (
    input logic           clk,
    input logic           clear,
    counter_modn_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    // Reject parameter sets that would allow an out-of-range count.
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("counter_modn: MODULUS must lie in 2..2**WIDTH");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset
        $error("counter_modn: RESET_VALUE must be below MODULUS");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             pgt_q, pgt_d;
    logic             halted_q, halted_d;
    logic             tc;
    logic             din_ok;

    // Terminal count follows the current direction with no latency.
    assign tc     = bus.up ? (q_q == MAX_VAL) : (q_q == '0);
    // Zero-extend din so a power-of-two MODULUS compares correctly.
    assign din_ok = 32'(bus.din) < MODULUS;

    // Next-state: clear is handled in the flop; here load beats count.
    always_comb begin
        q_d      = q_q;
        pgt_d    = 1'b0;
        halted_d = halted_q;
        if (bus.load) begin
            q_d      = din_ok ? bus.din : MAX_VAL;
            halted_d = 1'b0;
        end else if (bus.en) begin
            if (!tc) begin
                q_d      = bus.up ? q_q + 1'b1 : q_q - 1'b1;
                halted_d = 1'b0;
            end else if (bus.wrap_en) begin
                q_d      = bus.up ? '0 : MAX_VAL;
                pgt_d    = 1'b1;
                halted_d = 1'b0;
            end else if (!halted_q) begin
                // Saturate: park on the terminal value and pulse once only.
                pgt_d    = 1'b1;
                halted_d = 1'b1;
            end
        end
    end

    // State flops; clear acts immediately and also kills any pulse in flight.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_q      <= RST_VAL;
            pgt_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            pgt_q    <= pgt_d;
            halted_q <= halted_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.pgt    = pgt_q;
    assign bus.halted = halted_q;
    assign bus.tc     = tc;
endmodule

// File: tb/tb_counter_modn.sv
// Directed bench for counter_modn: vector table on a mod-7 instance, hand sequences
// for asynchronous clear, and a mod-10/mod-6 down-counting cascade from 59.
module tb_counter_modn;
    logic clk = 1'b0;
    logic clear7;
    logic clear_c;
    logic casc_en;
    logic casc_load;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_modn_if #(.WIDTH(3)) bus7 ();
    counter_modn_if #(.WIDTH(4)) bus_u ();
    counter_modn_if #(.WIDTH(3)) bus_t ();

    counter_modn #(.MODULUS(7), .WIDTH(3), .RESET_VALUE(0)) dut7 (
        .clk   (clk),
        .clear (clear7),
        .bus   (bus7)
    );

    counter_modn #(.MODULUS(10), .WIDTH(4), .RESET_VALUE(0)) dut_units (
        .clk   (clk),
        .clear (clear_c),
        .bus   (bus_u)
    );

    counter_modn #(.MODULUS(6), .WIDTH(3), .RESET_VALUE(0)) dut_tens (
        .clk   (clk),
        .clear (clear_c),
        .bus   (bus_t)
    );

    // Cascade wiring: tens steps on units terminal; units wraps until tens reaches zero.
    assign bus_u.en      = casc_en;
    assign bus_u.up      = 1'b0;
    assign bus_u.load    = casc_load;
    assign bus_u.din     = 4'd9;
    assign bus_u.wrap_en = ~bus_t.tc;
    assign bus_t.en      = bus_u.tc & casc_en;
    assign bus_t.up      = 1'b0;
    assign bus_t.load    = casc_load;
    assign bus_t.din     = 3'd5;
    assign bus_t.wrap_en = 1'b0;

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic       wrap_en;
        logic [2:0] din;
        logic [2:0] exp_q;
        logic       exp_pgt;
        logic       exp_tc;
        logic       exp_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic up, input logic load, input logic wrap_en,
                       input logic [2:0] din, input logic [2:0] q, input logic pgt,
                       input logic tc, input logic halted);
        vec_t v;
        v.en = en; v.up = up; v.load = load; v.wrap_en = wrap_en; v.din = din;
        v.exp_q = q; v.exp_pgt = pgt; v.exp_tc = tc; v.exp_halted = halted;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive7(input logic en, input logic up, input logic load,
                          input logic wrap_en, input logic [2:0] din);
        bus7.en = en; bus7.up = up; bus7.load = load; bus7.wrap_en = wrap_en; bus7.din = din;
    endtask

    initial begin
        clear7    = 1'b1;
        clear_c   = 1'b1;
        casc_en   = 1'b0;
        casc_load = 1'b0;
        drive7(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);

        // Wrap up from clear: 1..6, wrap to 0 with pulse, then 1.
        for (int k = 1; k <= 5; k++) add(1, 1, 0, 1, 0, 3'(k), 0, 0, 0);
        add(1, 1, 0, 1, 0, 6, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);
        // Load 2 then count down through 0 to 6 and 5.
        add(0, 0, 1, 1, 2, 2, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 6, 1, 0, 0);
        add(1, 0, 0, 1, 0, 5, 0, 0, 0);
        // Saturate down from 3: single pulse on halt, then parked.
        add(0, 0, 1, 0, 3, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1, 1);
        for (int k = 0; k < 6; k++) add(1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 0, 0, 0);
        // Hold, load clamp, load beats enable.
        add(0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 7, 6, 0, 1, 0);
        add(1, 1, 1, 0, 4, 4, 0, 0, 0);
        // Halted at 0, then wrap_en=1 wraps and pulses.
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1, 1);
        add(1, 0, 0, 1, 0, 6, 1, 0, 0);
        // Saturate upward, hold while parked, load clears halted.
        add(0, 1, 1, 0, 5, 5, 0, 0, 0);
        add(1, 1, 0, 0, 0, 6, 0, 1, 0);
        add(1, 1, 0, 0, 0, 6, 1, 1, 1);
        add(1, 1, 0, 0, 0, 6, 0, 1, 1);
        add(0, 1, 0, 0, 0, 6, 0, 1, 1);
        add(0, 1, 1, 0, 2, 2, 0, 0, 0);

        // Reset state while clear is held across edges.
        tick();
        tick();
        check("reset.q", 32'(bus7.q), 32'd0);
        check("reset.pgt", 32'(bus7.pgt), 32'd0);
        check("reset.halted", 32'(bus7.halted), 32'd0);
        check("reset.casc_q", 32'({bus_t.q, bus_u.q}), 32'd0);
        clear7 = 1'b0;

        foreach (vecs[i]) begin
            drive7(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].wrap_en, vecs[i].din);
            tick();
            check($sformatf("v%0d.q", i), 32'(bus7.q), 32'(vecs[i].exp_q));
            check($sformatf("v%0d.pgt", i), 32'(bus7.pgt), 32'(vecs[i].exp_pgt));
            check($sformatf("v%0d.tc", i), 32'(bus7.tc), 32'(vecs[i].exp_tc));
            check($sformatf("v%0d.halted", i), 32'(bus7.halted), 32'(vecs[i].exp_halted));
        end

        // Asynchronous clear between edges with q=5.
        drive7(1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
        tick();
        check("clr1.pre_q", 32'(bus7.q), 32'd5);
        #2 clear7 = 1'b1;
        #1;
        check("clr1.q", 32'(bus7.q), 32'd0);
        clear7 = 1'b0;

        // Asynchronous clear while pgt is high, then resume from reset value.
        drive7(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        tick();
        check("clr2.pre_q", 32'(bus7.q), 32'd6);
        check("clr2.pre_pgt", 32'(bus7.pgt), 32'd1);
        #2 clear7 = 1'b1;
        #1;
        check("clr2.q", 32'(bus7.q), 32'd0);
        check("clr2.pgt", 32'(bus7.pgt), 32'd0);
        clear7 = 1'b0;
        drive7(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        tick();
        check("clr2.resume_q", 32'(bus7.q), 32'd1);
        check("clr2.resume_pgt", 32'(bus7.pgt), 32'd0);

        // Cascade: load 59, count down to 00, then both park with one pulse each.
        clear_c   = 1'b0;
        casc_load = 1'b1;
        tick();
        casc_load = 1'b0;
        check("casc.load", 32'(bus_t.q) * 10 + 32'(bus_u.q), 32'd59);
        casc_en = 1'b1;
        for (int v = 58; v >= 0; v--) begin
            tick();
            check($sformatf("casc.q%0d", v), 32'(bus_t.q) * 10 + 32'(bus_u.q), 32'(v));
            check($sformatf("casc.upgt%0d", v), 32'(bus_u.pgt), (v % 10 == 9) ? 32'd1 : 32'd0);
            check($sformatf("casc.tpgt%0d", v), 32'(bus_t.pgt), 32'd0);
        end
        check("casc.zero_uhalt", 32'(bus_u.halted), 32'd0);
        tick();
        check("casc.park_q", 32'({bus_t.q, bus_u.q}), 32'd0);
        check("casc.park_upgt", 32'(bus_u.pgt), 32'd1);
        check("casc.park_tpgt", 32'(bus_t.pgt), 32'd1);
        check("casc.park_uhalt", 32'(bus_u.halted), 32'd1);
        check("casc.park_thalt", 32'(bus_t.halted), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("casc.after%0d.pgt", k), 32'({bus_t.pgt, bus_u.pgt}), 32'd0);
            check($sformatf("casc.after%0d.q", k), 32'({bus_t.q, bus_u.q}), 32'd0);
            check($sformatf("casc.after%0d.halt", k), 32'({bus_t.halted, bus_u.halted}), 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
